msk_state_unloader: RTL and testbench

MSK_STATE_UNLOADER -- requirements
Module: msk_state_unloader

---
 rtl/msk_state_unloader.sv | 106 ++++++++++
 tb/tb_msk_state_unloader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/msk_state_unloader.sv
// Unloads a loaded masked word as count/width beats, each bit keeping all d
// shares intact. The holding register is wiped on return to idle.
module msk_state_unloader #(
  parameter int d     = 2,
  parameter int count = 128,
  parameter int width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [count*d-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [width*d-1:0]   out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int N      = count / width;
  localparam int BEAT_W = width * d;
  localparam int IW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [count*d-1:0]     hold_q, hold_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;

  // Last-beat handshake frees the holding register in the same cycle.
  assign in_ready  = (state_q == IDLE) || (out_last_q && out_ready);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == SEND);

  always_comb begin
    out_data = '0;
    if (out_valid_q) begin
      out_data = hold_q[int'(idx_q)*BEAT_W +: BEAT_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          hold_d      = in_data;
          idx_d       = '0;
          state_d     = SEND;
          out_valid_d = 1'b1;
          out_last_d  = (N == 1);
        end
      end
      SEND: begin
        if (out_ready) begin
          if (!out_last_q) begin
            idx_d      = idx_q + IW'(1);
            out_last_d = ((idx_q + IW'(1)) == LAST_IDX);
          end else if (in_valid) begin
            hold_d     = in_data;
            idx_d      = '0;
            out_last_d = (N == 1);
          end else begin
            hold_d      = '0;
            idx_d       = '0;
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        hold_d      = '0;
        idx_d       = '0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_msk_state_unloader.sv
// Directed bench for msk_state_unloader with d=2, count=128, width=32 (4 beats).
module tb_msk_state_unloader;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [255:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic          out_last;
  logic          busy;

  int checks = 0;
  int errors = 0;

  msk_state_unloader #(.d(2), .count(128), .width(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] P1 = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
  localparam logic [127:0] P2 = 128'h8000_0001_A5A5_5A5A_0000_FFFF_1234_5678;
  localparam logic [127:0] P3 = 128'h0123_4567_89AB_CDEF_DEAD_BEEF_CAFE_F00D;
  localparam logic [127:0] P4 = 128'hFFFF_0000_C3C3_3C3C_5555_AAAA_0F0F_F0F0;

  // share0 of bit i = p[i], share1 = ~p[i]
  function automatic logic [255:0] word(input logic [127:0] p);
    logic [255:0] w;
    for (int i = 0; i < 128; i++) begin
      w[2*i]   = p[i];
      w[2*i+1] = ~p[i];
    end
    return w;
  endfunction

  function automatic logic [63:0] beat(input logic [127:0] p, input int k);
    logic [63:0] r;
    for (int b = 0; b < 32; b++) begin
      r[2*b]   = p[32*k+b];
      r[2*b+1] = ~p[32*k+b];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " out_last"},  64'(out_last),  64'd0);
    check({tag, " busy"},      64'(busy),      64'd0);
    check({tag, " in_ready"},  64'(in_ready),  64'd1);
    check({tag, " out_data"},  out_data,       64'd0);
  endtask

  task automatic check_beat(input string tag, input logic [127:0] p, input int k,
                            input logic exp_ready);
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check({tag, " busy"},      64'(busy),      64'd1);
    check({tag, " out_data"},  out_data,       beat(p, k));
    check({tag, " out_last"},  64'(out_last),  64'(k == 3));
    check({tag, " in_ready"},  64'(in_ready),  64'(exp_ready));
  endtask

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    check_idle("reset");
    tick();
    rst = 1'b0;
    tick();
    check_idle("post_reset");

    // streaming unload, out_ready held high
    in_valid = 1'b1; in_data = word(P1); out_ready = 1'b1;
    #1 check("load_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; in_data = '1;
    for (int c = 0; c < 4; c++) begin
      #1 check_beat($sformatf("stream b%0d", c), P1, c, c == 3);
      tick();
    end
    check_idle("stream_done");

    // stalled unload, out_ready pattern 1,0,0 repeating
    in_valid = 1'b1; in_data = word(P2);
    tick();
    in_valid = 1'b0; in_data = '0;
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      out_ready = ((c % 3) == 0);
      #1 check_beat($sformatf("stall c%0d", c), P2, k, out_ready && k == 3);
      if (out_ready) k++;
      tick();
    end
    check("stall_handshakes", 64'(k), 64'd4);
    check_idle("stall_done");

    // back-to-back words; second offered early must wait for last beat
    out_ready = 1'b1; in_valid = 1'b1; in_data = word(P3);
    tick();
    in_data = word(P4);
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 4);
      #1 check_beat($sformatf("b2b b%0d", c), (c < 4) ? P3 : P4, c % 4, (c % 4) == 3);
      tick();
    end
    check_idle("b2b_done");

    // asynchronous reset mid-word during beat 2
    in_valid = 1'b1; in_data = word(P1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #1 check_beat("pre_rst b2", P1, 2, 1'b0);
    #1 rst = 1'b1;
    #1 check_idle("async_rst");
    #2 rst = 1'b0;
    tick();
    check_idle("after_rst");
    in_valid = 1'b1; in_data = word(P2);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 check_beat($sformatf("rst_reload b%0d", c), P2, c, c == 3);
      tick();
    end
    check_idle("rst_reload_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
